mux_scan_ctrl: RTL and testbench
================================

# mux_scan_ctrl

Sequential scan controller that sits directly upstream of `mux_16x1` and drives its 4-bit `sel` input. It steps the select through all 16 channels, waits a programmable settle time on each, samples the mux's single-bit output, and reassembles the samples into a 16-bit word. The word is delivered over a valid/ready handshake. The block turns the combinational 16:1 mux into a framed bit-serial-to-parallel capture path.

## Interface
- `SETTLE_CYCLES`, default 1: idle cycles per channel before sampling; legal range 0..15.
- `clk_i` input, 1 bit: single clock; all state changes on the rising edge.
- `rst_ni` input, 1 bit: reset, asynchronous and active-low.
- `start_i` input, 1 bit: request one scan; sampled only in IDLE.
- `abort_i` input, 1 bit: synchronous abort of the current scan or hold.
- `mux_bit_i` input, 1 bit: `out_o` of the downstream `mux_16x1`.
- `sel_o` output, 4 bits: drives `sel` of `mux_16x1`.
- `busy_o` output, 1 bit: high in SCAN.
- `word_o` output, 16 bits: assembled word; bit n is the sample taken at `sel_o`=n.
- `valid_o` output, 1 bit: `word_o` is valid (HOLD).
- `ready_i` input, 1 bit: consumer accepts `word_o`.
- `scan_cnt_o` output, 8 bits: count of completed scans.

## Operation
- FSM states: IDLE, SCAN, HOLD. Reset state is IDLE.
- Reset values: `sel_o`=0, `busy_o`=0, `word_o`=16'h0000, `valid_o`=0, `scan_cnt_o`=0. Internal settle counter and shadow register are cleared.
- IDLE to SCAN: on `start_i`=1 and `abort_i`=0. `sel_o` is 0 and the settle counter is cleared.
- SCAN, each edge:
  - If settle counter < `SETTLE_CYCLES`, increment the counter.
  - Otherwise, write `mux_bit_i` into shadow bit `sel_o` and clear the counter.
  - If `sel_o`=15 at that sample, go to HOLD: `word_o` is loaded from shadow bits [14:0] plus the bit just sampled, `valid_o` goes to 1, and `scan_cnt_o` increments.
  - Otherwise, increment `sel_o`.
- HOLD: `word_o` and `valid_o` stay stable until a transfer occurs, i.e. an edge with `valid_o`=1 and `ready_i`=1. After the transfer, `valid_o`=0, `sel_o`=0, and the state returns to IDLE (see Configuration for auto-restart).
- `start_i` is ignored in SCAN and HOLD, with no queuing.
- `abort_i` in SCAN: go to IDLE with `sel_o`=0. The partial shadow is discarded; `word_o` and `scan_cnt_o` are unchanged.
- `abort_i` in HOLD: `valid_o`=0, go to IDLE. `word_o` keeps its value; no transfer is counted.
- `abort_i` together with `start_i` in IDLE: abort wins and the block stays in IDLE.
- `abort_i` together with a transfer in HOLD: go to IDLE (auto-restart suppressed). The transfer is considered complete.
- `scan_cnt_o` wraps from 255 to 0.
- Reset asserted mid-scan or mid-hold: all outputs take their reset values immediately (asynchronous).

## Timing
- Each channel occupies `SETTLE_CYCLES`+1 cycles, with `sel_o` held constant for that span.
- `start_i` accepted at edge k: `valid_o` rises at edge k+16·(`SETTLE_CYCLES`+1). With the default of 1, that is 32 cycles.
- The sample for channel n is taken at the last edge of its span, after `sel_o`=n has been stable for `SETTLE_CYCLES`+1 edges. The mux path is combinational, so `SETTLE_CYCLES`=0 is legal.
- `valid_o` drops at the same edge as the transfer. The minimum HOLD duration is 1 cycle.
- `sel_o` is registered and glitch-free, and changes only at sample edges or on entry to IDLE or SCAN.

## Configuration
- Macro: `MUX_SCAN_AUTO_EN`.
- Defined: a transfer in HOLD (without `abort_i`) goes directly to SCAN with `sel_o`=0 and the counter cleared. The next `valid_o` follows 16·(`SETTLE_CYCLES`+1) cycles after the transfer edge. `start_i` is not needed after the first scan. `abort_i` is the only way back to IDLE.
- Undefined: single-shot behaviour as described in Operation.

## Structure
- Package `mux_scan_pkg` holds:
  - the state enum (IDLE, SCAN, HOLD);
  - `N_CH`=16 and `SEL_W`=4;
  - `SCAN_CNT_W`=8.
- The settle counter width is $clog2(`SETTLE_CYCLES`+1), with a minimum of 1.
- Single module, no sub-module.
- The bench instantiates the existing `mux_16x1` between `sel_o` and `mux_bit_i`.

## Test plan
- Mux input 16'hABAB, `SETTLE_CYCLES`=0, pulse `start_i`, `ready_i`=1 → `sel_o` steps 0..F one per cycle; `valid_o` rises 16 cycles after start with `word_o`=16'hABAB; `scan_cnt_o`=1.
- Mux input 16'h1240, `SETTLE_CYCLES`=2 → each `sel_o` value held 3 cycles; `valid_o` at 48 cycles; `word_o`=16'h1240.
- Backpressure: `ready_i`=0 for 10 cycles in HOLD → `valid_o` stays 1 and `word_o` is stable; raise `ready_i` → `valid_o`=0 at that edge, IDLE, `sel_o`=0.
- `abort_i` while `sel_o`=5 → IDLE next edge, `valid_o` never rises, `word_o` and `scan_cnt_o` keep prior values. `abort_i`+`start_i` in IDLE → stays IDLE.
- Drop `rst_ni` mid-scan at `sel_o`=9 → all outputs at reset values without waiting for an edge. After release, `start_i` plus input 16'hFFF0 → `word_o`=16'hFFF0.
- With `MUX_SCAN_AUTO_EN`, input 16'hFFF0 then 16'hFFF4 with `ready_i`=1 → back-to-back words 16'hFFF0 and 16'hFFF4 with no IDLE gap. Run 256 scans → `scan_cnt_o` wraps to 0.

Source files
------------

// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the mux_scan_ctrl scan controller.
package mux_scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  localparam int N_CH       = 16;
  localparam int SEL_W      = 4;
  localparam int SCAN_CNT_W = 8;

  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(N_CH - 1);

  // The settle counter must be at least one bit wide, even when no settling is needed.
  function automatic int cnt_width(input int unsigned settle);
    return (settle < 1) ? 1 : $clog2(settle + 1);
  endfunction

endpackage

// File: rtl/mux_scan_ctrl_if.sv
// Valid/ready word delivery channel between mux_scan_ctrl and its consumer.
interface mux_scan_ctrl_if;
  import mux_scan_pkg::*;

  logic [N_CH-1:0] word_o;
  logic            valid_o;
  logic            ready_i;

  modport master (output word_o, output valid_o, input ready_i);
  modport slave  (input word_o, input valid_o, output ready_i);

endinterface

// File: rtl/mux_16x1.sv
// Combinational 16:1 single-bit multiplexer sampled by mux_scan_ctrl.
module mux_16x1 (
  input  logic [15:0] in_i,
  input  logic [3:0]  sel,
  output logic        out_o
);

  assign out_o = in_i[sel];

endmodule

// File: rtl/mux_scan_ctrl.sv
// Steps a 16:1 mux through all channels, samples each after a settle time and
// delivers the assembled word over valid/ready. Define MUX_SCAN_AUTO_EN for continuous rescanning.
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic                  mux_bit_i,
  output logic [SEL_W-1:0]      sel_o,
  output logic                  busy_o,
  output logic [SCAN_CNT_W-1:0] scan_cnt_o,
  mux_scan_ctrl_if.master       out_if
);

  localparam int               CNT_W      = cnt_width(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] SETTLE_MAX = CNT_W'(SETTLE_CYCLES);

  state_e                  state_q, state_d;
  logic [SEL_W-1:0]        sel_q, sel_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [N_CH-1:0]         shadow_q, shadow_d;
  logic [N_CH-1:0]         word_q, word_d;
  logic [SCAN_CNT_W-1:0]   scan_cnt_q, scan_cnt_d;

  always_comb begin
    // NOTE: every *_d gets its hold value first so no path through the case infers a latch.
    state_d    = state_q;
    sel_d      = sel_q;
    cnt_d      = cnt_q;
    shadow_d   = shadow_q;
    word_d     = word_q;
    scan_cnt_d = scan_cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start_i && !abort_i) begin
          state_d = ST_SCAN;
          sel_d   = '0;
          cnt_d   = '0;
        end
      end

      ST_SCAN: begin
        if (abort_i) begin
          state_d = ST_IDLE;
          sel_d   = '0;
          cnt_d   = '0;
        end else if (cnt_q < SETTLE_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          cnt_d           = '0;
          shadow_d[sel_q] = mux_bit_i;
          // The final word includes the bit sampled on this very edge.
          if (sel_q == SEL_LAST) begin
            state_d    = ST_HOLD;
            word_d     = shadow_d;
            scan_cnt_d = scan_cnt_q + 1'b1;
          end else begin
            sel_d = sel_q + 1'b1;
          end
        end
      end

      ST_HOLD: begin
        if (abort_i) begin
          state_d = ST_IDLE;
          sel_d   = '0;
        end else if (out_if.ready_i) begin
          sel_d = '0;
`ifdef MUX_SCAN_AUTO_EN
          state_d = ST_SCAN;
          cnt_d   = '0;
`else
          state_d = ST_IDLE;
`endif
        end
      end

      default: begin
        state_d = ST_IDLE;
        sel_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // NOTE: the shadow is a plain 16-bit register, not a memory, so it is cleared on reset like any flop.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      sel_q      <= '0;
      cnt_q      <= '0;
      shadow_q   <= '0;
      word_q     <= '0;
      scan_cnt_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge value of the others.
      state_q    <= state_d;
      sel_q      <= sel_d;
      cnt_q      <= cnt_d;
      shadow_q   <= shadow_d;
      word_q     <= word_d;
      scan_cnt_q <= scan_cnt_d;
    end
  end

  assign sel_o          = sel_q;
  assign busy_o         = (state_q == ST_SCAN);
  assign scan_cnt_o     = scan_cnt_q;
  assign out_if.word_o  = word_q;
  assign out_if.valid_o = (state_q == ST_HOLD);

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Self-checking bench for mux_scan_ctrl: two instances (settle 0 and 2) each driving a mux_16x1,
// with a per-instance scoreboard of delivered words.
module tb_mux_scan_ctrl;
  import mux_scan_pkg::*;

`ifdef MUX_SCAN_AUTO_EN
  localparam logic AUTO = 1'b1;
`else
  localparam logic AUTO = 1'b0;
`endif

  typedef struct {
    logic [15:0] word;
    logic [7:0]  cnt;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start0 = 1'b0, abort0 = 1'b0, mbit0, busy0;
  logic [15:0] mux_in0 = 16'h0000;
  logic [3:0]  sel0;
  logic [7:0]  cnt0;

  logic        start2 = 1'b0, abort2 = 1'b0, mbit2, busy2;
  logic [15:0] mux_in2 = 16'h0000;
  logic [3:0]  sel2;
  logic [7:0]  cnt2;

  mux_scan_ctrl_if if0 ();
  mux_scan_ctrl_if if2 ();

  mux_scan_ctrl #(.SETTLE_CYCLES(0)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start0), .abort_i(abort0), .mux_bit_i(mbit0),
    .sel_o(sel0), .busy_o(busy0), .scan_cnt_o(cnt0), .out_if(if0)
  );
  mux_16x1 u_mux0 (.in_i(mux_in0), .sel(sel0), .out_o(mbit0));

  mux_scan_ctrl #(.SETTLE_CYCLES(2)) u_dut2 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start2), .abort_i(abort2), .mux_bit_i(mbit2),
    .sel_o(sel2), .busy_o(busy2), .scan_cnt_o(cnt2), .out_if(if2)
  );
  mux_16x1 u_mux2 (.in_i(mux_in2), .sel(sel2), .out_o(mbit2));

  int          n_checks = 0;
  int          n_fail   = 0;
  exp_t        q0[$];
  exp_t        q2[$];
  exp_t        e0, e2;
  logic [15:0] last_word = 16'h0000;
  logic [7:0]  exp_cnt   = 8'd0;

  // Scoreboards: a transfer happens at the next edge whenever valid and ready are both high.
  always @(negedge clk) begin
    if (rst_n && if0.valid_o === 1'b1 && if0.ready_i === 1'b1) begin
      n_checks++;
      if (q0.size() == 0) begin
        n_fail++;
        $display("FAIL xfer0_unexpected: got word=%h cnt=%0d, expected no transfer", if0.word_o, cnt0);
      end else begin
        e0 = q0.pop_front();
        if (if0.word_o !== e0.word || cnt0 !== e0.cnt) begin
          n_fail++;
          $display("FAIL xfer0_word: got word=%h cnt=%0d, expected word=%h cnt=%0d",
                   if0.word_o, cnt0, e0.word, e0.cnt);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && if2.valid_o === 1'b1 && if2.ready_i === 1'b1) begin
      n_checks++;
      if (q2.size() == 0) begin
        n_fail++;
        $display("FAIL xfer2_unexpected: got word=%h cnt=%0d, expected no transfer", if2.word_o, cnt2);
      end else begin
        e2 = q2.pop_front();
        if (if2.word_o !== e2.word || cnt2 !== e2.cnt) begin
          n_fail++;
          $display("FAIL xfer2_word: got word=%h cnt=%0d, expected word=%h cnt=%0d",
                   if2.word_o, cnt2, e2.word, e2.cnt);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start0;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
  endtask

  task automatic idle0;
    abort0 = 1'b1;
    tick();
    abort0 = 1'b0;
  endtask

  task automatic expect0(input logic [15:0] w);
    exp_cnt   = exp_cnt + 8'd1;
    last_word = w;
    q0.push_back('{w, exp_cnt});
  endtask

  task automatic wait_valid0(output int cycles);
    cycles = 0;
    while (if0.valid_o !== 1'b1 && cycles < 200) begin
      tick();
      cycles++;
    end
  endtask

  task automatic wait_sel0(input logic [3:0] s);
    int budget = 0;
    while (sel0 !== s && budget < 100) begin
      tick();
      budget++;
    end
    n_checks++;
    if (sel0 !== s) begin
      n_fail++;
      $display("FAIL wait_sel0: got sel=%h, expected sel=%h within 100 cycles", sel0, s);
    end
  endtask

  task automatic test_reset;
    if0.ready_i = 1'b0;
    if2.ready_i = 1'b0;
    #3;
    n_checks++;
    if (sel0 !== 4'h0 || busy0 !== 1'b0 || if0.word_o !== 16'h0000 || if0.valid_o !== 1'b0 || cnt0 !== 8'd0) begin
      n_fail++;
      $display("FAIL reset0: got sel=%h busy=%b word=%h valid=%b cnt=%0d, expected all zero",
               sel0, busy0, if0.word_o, if0.valid_o, cnt0);
    end
    n_checks++;
    if (sel2 !== 4'h0 || busy2 !== 1'b0 || if2.word_o !== 16'h0000 || if2.valid_o !== 1'b0 || cnt2 !== 8'd0) begin
      n_fail++;
      $display("FAIL reset2: got sel=%h busy=%b word=%h valid=%b cnt=%0d, expected all zero",
               sel2, busy2, if2.word_o, if2.valid_o, cnt2);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_settle0;
    if0.ready_i = 1'b1;
    mux_in0     = 16'hABAB;
    expect0(16'hABAB);
    pulse_start0();
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (sel0 !== 4'(i) || if0.valid_o !== 1'b0 || busy0 !== 1'b1) begin
        n_fail++;
        $display("FAIL settle0_step%0d: got sel=%h valid=%b busy=%b, expected sel=%h valid=0 busy=1",
                 i, sel0, if0.valid_o, busy0, 4'(i));
      end
      tick();
    end
    n_checks++;
    if (if0.valid_o !== 1'b1 || if0.word_o !== 16'hABAB || cnt0 !== 8'd1) begin
      n_fail++;
      $display("FAIL settle0_done: got valid=%b word=%h cnt=%0d, expected valid=1 word=abab cnt=1",
               if0.valid_o, if0.word_o, cnt0);
    end
    tick();
    n_checks++;
    if (if0.valid_o !== 1'b0 || sel0 !== 4'h0 || busy0 !== AUTO) begin
      n_fail++;
      $display("FAIL settle0_after_xfer: got valid=%b sel=%h busy=%b, expected valid=0 sel=0 busy=%b",
               if0.valid_o, sel0, busy0, AUTO);
    end
    idle0();
  endtask

  task automatic test_settle2;
    if2.ready_i = 1'b1;
    mux_in2     = 16'h1240;
    q2.push_back('{16'h1240, 8'd1});
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 3; j++) begin
        n_checks++;
        if (sel2 !== 4'(i) || if2.valid_o !== 1'b0) begin
          n_fail++;
          $display("FAIL settle2_ch%0d_cyc%0d: got sel=%h valid=%b, expected sel=%h valid=0",
                   i, j, sel2, if2.valid_o, 4'(i));
        end
        tick();
      end
    end
    n_checks++;
    if (if2.valid_o !== 1'b1 || if2.word_o !== 16'h1240 || cnt2 !== 8'd1) begin
      n_fail++;
      $display("FAIL settle2_done: got valid=%b word=%h cnt=%0d, expected valid=1 word=1240 cnt=1",
               if2.valid_o, if2.word_o, cnt2);
    end
    tick();
    abort2 = 1'b1;
    tick();
    abort2 = 1'b0;
    n_checks++;
    if (if2.valid_o !== 1'b0 || busy2 !== 1'b0) begin
      n_fail++;
      $display("FAIL settle2_end: got valid=%b busy=%b, expected valid=0 busy=0", if2.valid_o, busy2);
    end
  endtask

  task automatic test_backpressure;
    int c;
    if0.ready_i = 1'b0;
    mux_in0     = 16'h5A3C;
    expect0(16'h5A3C);
    pulse_start0();
    wait_valid0(c);
    n_checks++;
    if (c !== 16) begin
      n_fail++;
      $display("FAIL bp_latency: got %0d cycles, expected 16", c);
    end
    for (int k = 0; k < 10; k++) begin
      n_checks++;
      if (if0.valid_o !== 1'b1 || if0.word_o !== 16'h5A3C) begin
        n_fail++;
        $display("FAIL bp_hold%0d: got valid=%b word=%h, expected valid=1 word=5a3c", k, if0.valid_o, if0.word_o);
      end
      tick();
    end
    if0.ready_i = 1'b1;
    tick();
    n_checks++;
    if (if0.valid_o !== 1'b0 || sel0 !== 4'h0 || busy0 !== AUTO) begin
      n_fail++;
      $display("FAIL bp_release: got valid=%b sel=%h busy=%b, expected valid=0 sel=0 busy=%b",
               if0.valid_o, sel0, busy0, AUTO);
    end
    idle0();
  endtask

  task automatic test_abort;
    int c;
    int rises = 0;
    if0.ready_i = 1'b1;
    mux_in0     = 16'hFFFF;
    pulse_start0();
    wait_sel0(4'h5);
    idle0();
    n_checks++;
    if (busy0 !== 1'b0 || sel0 !== 4'h0 || if0.valid_o !== 1'b0 || if0.word_o !== last_word || cnt0 !== exp_cnt) begin
      n_fail++;
      $display("FAIL abort_scan: got busy=%b sel=%h valid=%b word=%h cnt=%0d, expected busy=0 sel=0 valid=0 word=%h cnt=%0d",
               busy0, sel0, if0.valid_o, if0.word_o, cnt0, last_word, exp_cnt);
    end
    for (int k = 0; k < 40; k++) begin
      if (if0.valid_o === 1'b1) rises++;
      tick();
    end
    n_checks++;
    if (rises !== 0) begin
      n_fail++;
      $display("FAIL abort_no_valid: got valid high for %0d cycles, expected 0", rises);
    end
    abort0 = 1'b1;
    start0 = 1'b1;
    tick();
    abort0 = 1'b0;
    start0 = 1'b0;
    tick();
    n_checks++;
    if (busy0 !== 1'b0 || sel0 !== 4'h0) begin
      n_fail++;
      $display("FAIL abort_start_idle: got busy=%b sel=%h, expected busy=0 sel=0", busy0, sel0);
    end
    // Abort while holding: word kept, scan counted, no transfer.
    if0.ready_i = 1'b0;
    mux_in0     = 16'h3C5A;
    exp_cnt     = exp_cnt + 8'd1;
    last_word   = 16'h3C5A;
    pulse_start0();
    wait_valid0(c);
    idle0();
    n_checks++;
    if (c !== 16 || if0.valid_o !== 1'b0 || busy0 !== 1'b0 || if0.word_o !== 16'h3C5A || cnt0 !== exp_cnt) begin
      n_fail++;
      $display("FAIL abort_hold: got lat=%0d valid=%b busy=%b word=%h cnt=%0d, expected lat=16 valid=0 busy=0 word=3c5a cnt=%0d",
               c, if0.valid_o, busy0, if0.word_o, cnt0, exp_cnt);
    end
    // Abort coinciding with a transfer: word delivered, back to idle.
    mux_in0 = 16'h0F0F;
    expect0(16'h0F0F);
    pulse_start0();
    wait_valid0(c);
    if0.ready_i = 1'b1;
    idle0();
    n_checks++;
    if (c !== 16 || if0.valid_o !== 1'b0 || busy0 !== 1'b0 || sel0 !== 4'h0) begin
      n_fail++;
      $display("FAIL abort_xfer: got lat=%0d valid=%b busy=%b sel=%h, expected lat=16 valid=0 busy=0 sel=0",
               c, if0.valid_o, busy0, sel0);
    end
  endtask

  task automatic test_reset_mid;
    int c;
    if0.ready_i = 1'b1;
    mux_in0     = 16'hFFFF;
    pulse_start0();
    wait_sel0(4'h9);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (sel0 !== 4'h0 || busy0 !== 1'b0 || if0.word_o !== 16'h0000 || if0.valid_o !== 1'b0 || cnt0 !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_mid: got sel=%h busy=%b word=%h valid=%b cnt=%0d, expected all zero",
               sel0, busy0, if0.word_o, if0.valid_o, cnt0);
    end
    exp_cnt   = 8'd0;
    last_word = 16'h0000;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    mux_in0 = 16'hFFF0;
    expect0(16'hFFF0);
    pulse_start0();
    wait_valid0(c);
    n_checks++;
    if (c !== 16 || if0.word_o !== 16'hFFF0 || cnt0 !== 8'd1) begin
      n_fail++;
      $display("FAIL reset_mid_rescan: got lat=%0d word=%h cnt=%0d, expected lat=16 word=fff0 cnt=1",
               c, if0.word_o, cnt0);
    end
    tick();
    idle0();
  endtask

`ifdef MUX_SCAN_AUTO_EN
  task automatic test_back_to_back;
    int c;
    if0.ready_i = 1'b1;
    mux_in0     = 16'hFFF0;
    expect0(16'hFFF0);
    pulse_start0();
    wait_valid0(c);
    mux_in0 = 16'hFFF4;
    expect0(16'hFFF4);
    tick();
    n_checks++;
    if (c !== 16 || busy0 !== 1'b1 || sel0 !== 4'h0) begin
      n_fail++;
      $display("FAIL b2b_restart: got lat=%0d busy=%b sel=%h, expected lat=16 busy=1 sel=0", c, busy0, sel0);
    end
    wait_valid0(c);
    n_checks++;
    if (c !== 16 || if0.word_o !== 16'hFFF4) begin
      n_fail++;
      $display("FAIL b2b_second: got lat=%0d word=%h, expected lat=16 word=fff4", c, if0.word_o);
    end
    tick();
    idle0();
  endtask
`endif

  task automatic test_wrap;
    int          c;
    logic [15:0] w;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    exp_cnt     = 8'd0;
    if0.ready_i = 1'b1;
    for (int s = 0; s < 256; s++) begin
      w       = 16'($urandom);
      mux_in0 = w;
      expect0(w);
      if (!AUTO || s == 0) pulse_start0();
      wait_valid0(c);
      n_checks++;
      if (c !== 16) begin
        n_fail++;
        $display("FAIL wrap_latency%0d: got %0d cycles, expected 16", s, c);
      end
      tick();
    end
    n_checks++;
    if (cnt0 !== 8'd0) begin
      n_fail++;
      $display("FAIL wrap_count: got cnt=%0d, expected 0 after 256 scans", cnt0);
    end
    idle0();
  endtask

  initial begin
    test_reset();
    test_settle0();
    test_settle2();
    test_backpressure();
    test_abort();
    test_reset_mid();
`ifdef MUX_SCAN_AUTO_EN
    test_back_to_back();
`endif
    test_wrap();
    repeat (3) tick();
    n_checks++;
    if (q0.size() != 0 || q2.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d/%0d words outstanding, expected 0/0", q0.size(), q2.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
